// File: rtl/vector_fma_issue_sequencer.sv
// Issue sequencer for whole-register vector FP multiply-add: slices operands into 128-bit beats,
// tracks fixed-latency FMA returns and assembles a tail-undisturbed VLEN-bit result.
module vector_fma_issue_sequencer #(
  parameter int VLEN        = 512,
  parameter int FMA_LATENCY = 3
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          instruction_valid_i,
  output logic                          instruction_ready_o,
  input  logic                          negate_product_i,
  input  logic                          multiplication_addition_subtraction_i,
  input  logic                          overwrite_addend_multiplicand_i,
  input  logic [1:0]                    vsew_i,
  input  logic [$clog2(VLEN/8):0]       vl_i,
  input  logic [VLEN-1:0]               vs2_i,
  input  logic [VLEN-1:0]               vs1_i,
  input  logic [VLEN-1:0]               vd_old_i,
  output logic                          fma_request_o,
  output logic [1:0]                    fma_vsew_o,
  output logic                          fma_negate_product_o,
  output logic                          fma_multiplication_addition_subtraction_o,
  output logic                          fma_overwrite_addend_multiplicand_o,
  output logic [127:0]                  fma_vs2_o,
  output logic [127:0]                  fma_vs1_o,
  output logic [127:0]                  fma_vd_old_o,
  input  logic [127:0]                  fma_vd_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic [VLEN-1:0]               vd_o,
  output logic                          result_error_o
);

  localparam int BEATS = VLEN / 128;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VLW   = $clog2(VLEN/8) + 1;
  localparam logic [VLW-1:0] VLMAX8 = VLW'(VLEN/8);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [VLEN-1:0] vd_q, vd_d;
  logic            err_q, err_d;

  logic [VLEN-1:0] vs2_q, vs1_q, vd_old_q;
  logic [1:0]      vsew_q;
  logic            neg_q, mas_q, ovr_q;
  logic [VLW-1:0]  bytes_q;
  logic [BW-1:0]   last_beat_q;

  logic            infl_vld_q [FMA_LATENCY];
  logic [BW-1:0]   infl_idx_q [FMA_LATENCY];

  logic            accept, issue, cap;
  logic [BW-1:0]   cap_idx;
  logic [VLW-1:0]  vlmax, vl_clamp, bytes_in, bytes_m1;
  logic [BW+6:0]   issue_off, cap_off;
  logic [127:0]    cur_beat, merged_beat;

  assign accept  = instruction_valid_i && (state_q == S_IDLE);
  assign issue   = (state_q == S_ISSUE);
  assign cap_idx = infl_idx_q[FMA_LATENCY-1];
  assign cap     = infl_vld_q[FMA_LATENCY-1] && (state_q == S_ISSUE || state_q == S_DRAIN);

  // Active length in bytes after clamping vl to VLMAX; the last issued beat covers its final byte.
  assign vlmax    = VLMAX8 >> vsew_i;
  assign vl_clamp = (vl_i > vlmax) ? vlmax : vl_i;
  assign bytes_in = vl_clamp << vsew_i;
  assign bytes_m1 = bytes_in - VLW'(1);

  assign issue_off = {beat_q, 7'd0};
  assign cap_off   = {cap_idx, 7'd0};

  always_ff @(posedge clock_i) begin
    if (accept) begin
      vs2_q       <= vs2_i;
      vs1_q       <= vs1_i;
      vd_old_q    <= vd_old_i;
      vsew_q      <= vsew_i;
      neg_q       <= negate_product_i;
      mas_q       <= multiplication_addition_subtraction_i;
      ovr_q       <= overwrite_addend_multiplicand_i;
      bytes_q     <= bytes_in;
      last_beat_q <= bytes_m1[BW+3:4];
    end
  end

  always_comb begin
    cur_beat    = vd_q[cap_off +: 128];
    merged_beat = cur_beat;
    for (int j = 0; j < 16; j++) begin
      if ((int'(cap_idx) * 16 + j) < int'(bytes_q)) merged_beat[j*8 +: 8] = fma_vd_i[j*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    vd_d    = vd_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          vd_d  = vd_old_i;
          err_d = 1'b0;
          if (vsew_i == 2'b00) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (vl_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            beat_d  = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        beat_d = beat_q + BW'(1);
        if (beat_q == last_beat_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cap && cap_idx == last_beat_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (result_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (cap) vd_d[cap_off +: 128] = merged_beat;
  end

  // In-flight tracker: one slot per FMA pipeline stage, tagged with the beat it will return.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      vd_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < FMA_LATENCY; i++) begin
        infl_vld_q[i] <= 1'b0;
        infl_idx_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      vd_q    <= vd_d;
      err_q   <= err_d;
      for (int i = FMA_LATENCY-1; i > 0; i--) begin
        infl_vld_q[i] <= infl_vld_q[i-1];
        infl_idx_q[i] <= infl_idx_q[i-1];
      end
      infl_vld_q[0] <= issue;
      infl_idx_q[0] <= beat_q;
    end
  end

  assign instruction_ready_o = (state_q == S_IDLE);
  assign result_valid_o      = (state_q == S_DONE);
  assign vd_o                = vd_q;
  assign result_error_o      = err_q;

  assign fma_request_o                             = issue;
  assign fma_vsew_o                                = issue ? vsew_q : 2'b00;
  assign fma_negate_product_o                      = issue & neg_q;
  assign fma_multiplication_addition_subtraction_o = issue & mas_q;
  assign fma_overwrite_addend_multiplicand_o       = issue & ovr_q;
  assign fma_vs2_o                                 = issue ? vs2_q[issue_off +: 128] : '0;
  assign fma_vs1_o                                 = issue ? vs1_q[issue_off +: 128] : '0;
  assign fma_vd_old_o                              = issue ? vd_old_q[issue_off +: 128] : '0;

endmodule

// File: doc/vector_fma_issue_sequencer.md
Name: vector_fma_issue_sequencer

Overview:
- Upstream issue stage for vector_floating_point_multiplication_addition_unit.
- Accepts one whole-register vector FP multiply-add instruction (VLEN-bit vs2/vs1/vd_old, vl, vsew, op bits).
- Slices the operands into 128-bit beats and issues one beat per cycle to the FMA unit.
- Collects the fixed-latency results, merges tail elements (tail-undisturbed) and presents the full VLEN-bit vd with a valid/ready handshake.

Parameters:
- VLEN, 512, vector register width in bits; multiple of 128.
- FMA_LATENCY, 3, cycles from a sampled fma_request_o to fma_vd_i valid; must be ≥1.

Ports:
- clock_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- instruction_valid_i  in  1  instruction offered.
- instruction_ready_o  out  1  sequencer idle and can accept.
- negate_product_i  in  1  op bit; meaning as in the FMA unit.
- multiplication_addition_subtraction_i  in  1  op bit.
- overwrite_addend_multiplicand_i  in  1  op bit.
- vsew_i  in  2  00=8b, 01=16b, 10=32b, 11=64b.
- vl_i  in  $clog2(VLEN/8)+1  active element count.
- vs2_i  in  VLEN  source operand.
- vs1_i  in  VLEN  source operand.
- vd_old_i  in  VLEN  source operand.
- fma_request_o  out  1  beat valid to the FMA.
- fma_vsew_o  out  2  vsew for the beat.
- fma_negate_product_o  out  1  registered op bit.
- fma_multiplication_addition_subtraction_o  out  1  registered op bit.
- fma_overwrite_addend_multiplicand_o  out  1  registered op bit.
- fma_vs2_o  out  128  beat slice of vs2.
- fma_vs1_o  out  128  beat slice of vs1.
- fma_vd_old_o  out  128  beat slice of vd_old.
- fma_vd_i  in  128  FMA result, FMA_LATENCY cycles after request.
- result_valid_o  out  1  vd_o complete.
- result_ready_i  in  1  consumer accepts the result.
- vd_o  out  VLEN  merged result.
- result_error_o  out  1  qualified by result_valid_o; set for illegal vsew.

Behaviour:
- Reset (async, any state): state=IDLE; instruction_ready_o=1; fma_request_o=0; all fma_* outputs=0; result_valid_o=0; result_error_o=0; vd_o=0; in-flight tracking cleared. FMA returns arriving after reset are ignored.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: instruction_ready_o=1.
  - On valid&ready, register all inputs.
  - Clamp vl to VLMAX=VLEN/SEW.
  - N = ceil(vl*SEW/128).
  - vsew=00: go to DONE with vd_o=vd_old, result_error_o=1, no issue.
  - vl=0: go to DONE with vd_o=vd_old, error=0, no issue.
  - Otherwise go to ISSUE with beat index=0.
- ISSUE: fma_request_o=1 every cycle.
  - Drive slices [128*b+:128] of vs2/vs1/vd_old plus the registered vsew and op bits for beat index b; b increments each cycle.
  - After beat N-1 is issued, go to DRAIN.
  - The FMA unit has no backpressure; issue never stalls.
- In-flight tracking: a FMA_LATENCY-deep shift register carries {valid, beat index}.
  - When its output is valid, sample fma_vd_i into result beat b.
  - Byte-merge per byte position p = 16*b + byte: take fma_vd_i if p < vl*(SEW/8), else keep vd_old.
  - Beats ≥ N are never issued and remain vd_old.
- DRAIN: fma_request_o=0; wait until the last beat is captured, then go to DONE.
- DONE: result_valid_o=1; vd_o and result_error_o held stable; instruction_ready_o=0.
  - On result_ready_i go to IDLE; the next instruction may be accepted the cycle after.
- Timing: accept at edge 0; beats issued in cycles 1..N; beat k captured at end of cycle k+FMA_LATENCY.
  - result_valid_o rises in cycle N+FMA_LATENCY+1.
  - No overlap between instructions.
- In states other than IDLE, instruction_valid_i is ignored and the registered inputs are unaffected by input changes.

Test Plan:
- VLEN=512, vsew=10, vl=16, op=000.
  - Stimulus: every vs2 element 0x40000000 (2.0), vs1 0x40400000 (3.0), vd_old 0x3F800000 (1.0).
  - Required: fma_request_o high exactly 4 cycles with slices 0..3; result_valid_o in cycle 8; all 16 elements 0x40E00000 (7.0).
- Same operands, op=110, vl=5.
  - Required: 2 beats issued; elements 0..4 = 0xC0E00000 (−7.0); elements 5..15 = 0x3F800000.
- vsew=11, vl=3, vs2=2.0, vs1=3.0, vd_old=1.0 (double precision).
  - Required: 2 beats issued; elements 0..2 = 0x401C000000000000; element 3..7 unchanged.
- vl=0 and, separately, vsew=00.
  - Required: fma_request_o never asserted; result_valid_o in cycle 1; vd_o=vd_old; result_error_o=0 and 1 respectively.
- Hold result_ready_i low 5 cycles in DONE while driving instruction_valid_i=1.
  - Required: vd_o stable; instruction_ready_o=0; no new accept; accept occurs the cycle after the result handshake.
- Assert reset_i mid-ISSUE, after 2 of 4 beats.
  - Required: outputs immediately take reset values; late FMA returns are ignored; a subsequent instruction completes correctly.
